// File: rtl/beta_dmem_responder.sv
// Purpose: word-organised data memory answering the core's load/store ready/valid requests.
// Latency: response valid LATENCY+1 cycles after acceptance; one request outstanding at a time.
// Backpressure: response held stable until rsp_ready; req_ready low from acceptance until the cycle after the response handshake.
// Build option: BETA_DMEM_STALL_INJECT_EN adds LFSR-driven stalls on req_ready (IDLE) and rsp_valid (RESP).
module beta_dmem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1,
    parameter int XLEN    = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_op,
    input  logic [1:0]      req_size,
    input  logic [31:0]     req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] LAT = 4'(LATENCY);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    logic [1:0]      state;
    logic [3:0]      cnt;
    logic            lat_op;
    logic [1:0]      lat_size;
    logic [31:0]     lat_addr;
    logic [XLEN-1:0] lat_wdata;

    logic [XLEN-1:0] mem [DEPTH];

    logic            accept;
    logic            rsp_fire;
    logic            go_resp;
    logic            acc_op;
    logic [1:0]      acc_size;
    logic [31:0]     acc_addr;
    logic [XLEN-1:0] acc_wdata;
    logic [AW-1:0]   acc_idx;
    logic            acc_err;
    logic [3:0]      acc_be;
    logic [XLEN-1:0] acc_wlane;
    logic [XLEN-1:0] acc_rdata;
    logic [XLEN-1:0] rd_word;

`ifdef BETA_DMEM_STALL_INJECT_EN
    logic [7:0] lfsr;

    // Free-running 8-bit Fibonacci LFSR (taps 8,6,5,4) supplying stall decisions.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= 8'hA5;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign req_ready = (state == S_IDLE) && lfsr[0];
    assign rsp_valid = (state == S_RESP) && lfsr[1];
`else
    assign req_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_RESP);
`endif

    assign accept   = req_valid && req_ready;
    assign rsp_fire = rsp_valid && rsp_ready;

    // The array is touched on the edge that enters RESP; with zero latency that is the accept edge.
    assign go_resp = (LATENCY == 0) ? accept : ((state == S_WAIT) && (cnt == LAT));

    // While still in IDLE the request has not been latched yet, so use the live inputs.
    assign acc_op    = (state == S_IDLE) ? req_op    : lat_op;
    assign acc_size  = (state == S_IDLE) ? req_size  : lat_size;
    assign acc_addr  = (state == S_IDLE) ? req_addr  : lat_addr;
    assign acc_wdata = (state == S_IDLE) ? req_wdata : lat_wdata;
    assign acc_idx   = acc_addr[AW+1:2];

    // Decode size/alignment/range into an error flag, byte enables, store lanes and load data.
    always_comb begin
        acc_err   = 1'b0;
        acc_be    = 4'b0000;
        acc_wlane = '0;
        acc_rdata = '0;
        rd_word   = mem[acc_idx];
        case (acc_size)
            SZ_WORD: begin
                acc_err   = (acc_addr[1:0] != 2'b00);
                acc_be    = 4'b1111;
                acc_wlane = acc_wdata;
                acc_rdata = rd_word;
            end
            SZ_HALF: begin
                acc_err   = acc_addr[0];
                acc_be    = acc_addr[1] ? 4'b1100 : 4'b0011;
                acc_wlane = {2{acc_wdata[15:0]}};
                acc_rdata = {16'd0, (acc_addr[1] ? rd_word[31:16] : rd_word[15:0])};
            end
            SZ_BYTE: begin
                acc_be    = 4'b0001 << acc_addr[1:0];
                acc_wlane = {4{acc_wdata[7:0]}};
                acc_rdata = {24'd0, rd_word[{acc_addr[1:0], 3'b000} +: 8]};
            end
            default: acc_err = 1'b1;
        endcase
        if (|acc_addr[31:AW+2]) begin
            acc_err = 1'b1;
        end
    end

    // Capture the request on acceptance; held unchanged until the next acceptance.
    always_ff @(posedge clk) begin
        if (accept) begin
            lat_op    <= req_op;
            lat_size  <= req_size;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
        end
    end

    // Store path: only the selected lanes of a legal store are written; reset cancels the access.
    always_ff @(posedge clk) begin
        if (!rst && go_resp && acc_op && !acc_err) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_be[b]) begin
                    mem[acc_idx][b*8 +: 8] <= acc_wlane[b*8 +: 8];
                end
            end
        end
    end

    // Control FSM, wait counter and registered response fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state <= (LATENCY == 0) ? S_RESP : S_WAIT;
                        cnt   <= 4'd1;
                    end
                end
                S_WAIT: begin
                    if (cnt == LAT) begin
                        state <= S_RESP;
                        cnt   <= 4'd0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_fire) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
            if (go_resp) begin
                rsp_err   <= acc_err;
                rsp_rdata <= (acc_err || acc_op) ? '0 : acc_rdata;
            end
        end
    end

endmodule

// File: tb/tb_beta_dmem_responder.sv
// Bench for beta_dmem_responder: randomized and directed load/store traffic against a byte-level reference model.
// Instance a runs LATENCY=1, instance b runs LATENCY=4 for the mid-wait reset scenario.
// Prints one summary line and finishes; every wait is bounded.
module tb_beta_dmem_responder;

    localparam int DEPTH = 256;
    localparam int AW    = $clog2(DEPTH);

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst, a_req_valid, a_req_ready, a_req_op, a_rsp_valid, a_rsp_ready, a_rsp_err;
    logic [1:0]  a_req_size;
    logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;
    logic        b_rst, b_req_valid, b_req_ready, b_req_op, b_rsp_valid, b_rsp_ready, b_rsp_err;
    logic [1:0]  b_req_size;
    logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;

    int errors = 0;
    int checks = 0;
    int stall_seen = 0;

    logic [31:0] mdl [DEPTH];

    beta_dmem_responder #(.DEPTH(DEPTH), .LATENCY(1), .XLEN(32)) u_dut_a (
        .clk(clk), .rst(a_rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_op(a_req_op),
        .req_size(a_req_size), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
    );

    beta_dmem_responder #(.DEPTH(DEPTH), .LATENCY(4), .XLEN(32)) u_dut_b (
        .clk(clk), .rst(b_rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_op(b_req_op),
        .req_size(b_req_size), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
    );

    // Reference model: memory as bytes-in-words, access width in bytes, shift/mask arithmetic.
    function automatic void mdl_access(input logic op, input logic [1:0] size, input logic [31:0] addr,
                                       input logic [31:0] wdata, output logic [31:0] rdata, output logic err);
        int unsigned nb, a, sh;
        logic [63:0] mask;
        logic [AW-1:0] idx;
        a = addr;
        nb = (size == 2'd0) ? 4 : (size == 2'd1) ? 2 : (size == 2'd2) ? 1 : 0;
        rdata = 32'd0;
        if (nb == 0) err = 1'b1;
        else err = ((a % nb) != 0) || ((a / 4) >= DEPTH);
        if (!err) begin
            idx  = AW'(a / 4);
            sh   = 8 * (a % 4);
            mask = (64'd1 << (8 * nb)) - 64'd1;
            if (op) mdl[idx] = 32'((64'(mdl[idx]) & ~(mask << sh)) | ((64'(wdata) & mask) << sh));
            else    rdata = 32'((64'(mdl[idx]) >> sh) & mask);
        end
    endfunction

    // One complete transfer on instance a; returns observed response, model expectation, and latency.
    task automatic do_xact(input logic op, input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rdata, output logic err,
                           output logic [31:0] exp_rdata, output logic exp_err, output int lat);
        bit ok;
        mdl_access(op, size, addr, wdata, exp_rdata, exp_err);
        rdata = 'x; err = 'x; lat = -1;
        @(negedge clk);
        a_req_valid = 1'b1; a_req_op = op; a_req_size = size; a_req_addr = addr; a_req_wdata = wdata;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (a_req_ready) begin ok = 1'b1; break; end
            stall_seen++;
            @(negedge clk);
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL accept_timeout addr=%h req_ready stayed low", addr);
            a_req_valid = 1'b0;
            return;
        end
        @(negedge clk);
        // Scramble the request lines after acceptance; the latched request must not follow them.
        a_req_valid = 1'b0; a_req_addr = $urandom; a_req_wdata = $urandom;
        a_req_size = 2'($urandom); a_req_op = 1'($urandom);
        lat = 1; ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (a_rsp_valid) begin ok = 1'b1; break; end
            @(negedge clk);
            lat++;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL response_timeout addr=%h rsp_valid stayed low", addr);
            return;
        end
        rdata = a_rsp_rdata; err = a_rsp_err;
        a_rsp_ready = 1'b1;
        @(negedge clk);
        a_rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        a_rst = 1'b1; b_rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (a_req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", a_req_ready); end
        checks++; if (a_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", a_rsp_valid); end
        checks++; if (a_rsp_rdata !== 32'd0) begin errors++; $display("FAIL reset_rsp_rdata got=%h exp=0", a_rsp_rdata); end
        checks++; if (a_rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got=%b exp=0", a_rsp_err); end
        checks++; if (b_req_ready !== 1'b1) begin errors++; $display("FAIL reset_b_req_ready got=%b exp=1", b_req_ready); end
        a_rst = 1'b0; b_rst = 1'b0;
    endtask

    task automatic test_word();
        logic [31:0] rd, erd; logic e, ee; int lat;
        do_xact(1'b1, 2'b00, 32'h10, 32'hDEADBEEF, rd, e, erd, ee, lat);
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL word_store_err got=%b exp=0", e); end
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL word_store_rdata got=%h exp=0", rd); end
        do_xact(1'b0, 2'b00, 32'h10, 32'h0, rd, e, erd, ee, lat);
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL word_load_rdata got=%h exp=deadbeef", rd); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL word_load_err got=%b exp=0", e); end
`ifndef BETA_DMEM_STALL_INJECT_EN
        checks++; if (lat != 2) begin errors++; $display("FAIL word_load_latency got=%0d exp=2", lat); end
`endif
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd, erd; logic e, ee; int lat;
        do_xact(1'b1, 2'b00, 32'h20, 32'h11223344, rd, e, erd, ee, lat);
        do_xact(1'b1, 2'b10, 32'h22, 32'hFFFFFFAB, rd, e, erd, ee, lat);
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL byte_store_err got=%b exp=0", e); end
        do_xact(1'b0, 2'b00, 32'h20, 32'h0, rd, e, erd, ee, lat);
        checks++; if (rd !== 32'h11AB3344) begin errors++; $display("FAIL byte_lane_word got=%h exp=11ab3344", rd); end
        do_xact(1'b0, 2'b10, 32'h23, 32'h0, rd, e, erd, ee, lat);
        checks++; if (rd !== 32'h00000011) begin errors++; $display("FAIL byte_load got=%h exp=00000011", rd); end
        do_xact(1'b0, 2'b01, 32'h22, 32'h0, rd, e, erd, ee, lat);
        checks++; if (rd !== 32'h000011AB) begin errors++; $display("FAIL half_load got=%h exp=000011ab", rd); end
        do_xact(1'b1, 2'b01, 32'h20, 32'h5566CAFE, rd, e, erd, ee, lat);
        do_xact(1'b0, 2'b00, 32'h20, 32'h0, rd, e, erd, ee, lat);
        checks++; if (rd !== erd) begin errors++; $display("FAIL half_store_word got=%h exp=%h", rd, erd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd, erd; logic e, ee; int lat;
        logic        t_op   [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [1:0]  t_size [5] = '{2'b00, 2'b01, 2'b11, 2'b00, 2'b00};
        logic [31:0] t_addr [5] = '{32'h13, 32'h21, 32'h20, 32'(DEPTH * 4), 32'(DEPTH * 4 + 16)};
        for (int i = 0; i < 5; i++) begin
            do_xact(t_op[i], t_size[i], t_addr[i], 32'h0BADF00D, rd, e, erd, ee, lat);
            checks++; if (e !== 1'b1) begin errors++; $display("FAIL err_flag case=%0d got=%b exp=1", i, e); end
            checks++; if (rd !== 32'd0) begin errors++; $display("FAIL err_rdata case=%0d got=%h exp=0", i, rd); end
        end
        do_xact(1'b0, 2'b00, 32'h20, 32'h0, rd, e, erd, ee, lat);
        checks++; if (rd !== erd) begin errors++; $display("FAIL err_untouched_20 got=%h exp=%h", rd, erd); end
        do_xact(1'b0, 2'b00, 32'h10, 32'h0, rd, e, erd, ee, lat);
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL err_untouched_10 got=%h exp=deadbeef", rd); end
    endtask

    task automatic test_backpressure();
        logic [31:0] held; bit ok;
        @(negedge clk);
        a_req_valid = 1'b1; a_req_op = 1'b0; a_req_size = 2'b00; a_req_addr = 32'h10; a_req_wdata = 32'h0;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (a_req_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        @(negedge clk);
        a_req_valid = 1'b0;
        for (int i = 0; i < 200 && ok; i++) begin
            if (a_rsp_valid) break;
            @(negedge clk);
        end
        checks++; if (!ok || a_rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_reach_resp got=%b exp=1", a_rsp_valid); end
        held = a_rsp_rdata;
        checks++; if (held !== 32'hDEADBEEF) begin errors++; $display("FAIL bp_rdata got=%h exp=deadbeef", held); end
        a_req_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
`ifndef BETA_DMEM_STALL_INJECT_EN
            checks++; if (a_rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_hold cyc=%0d got=%b exp=1", c, a_rsp_valid); end
`endif
            checks++; if (a_rsp_rdata !== held) begin errors++; $display("FAIL bp_rdata_hold cyc=%0d got=%h exp=%h", c, a_rsp_rdata, held); end
            checks++; if (a_req_ready !== 1'b0) begin errors++; $display("FAIL bp_req_ready cyc=%0d got=%b exp=0", c, a_req_ready); end
        end
        for (int i = 0; i < 200; i++) begin
            if (a_rsp_valid) break;
            @(negedge clk);
        end
        a_rsp_ready = 1'b1;
        @(negedge clk);
        a_rsp_ready = 1'b0;
        a_req_valid = 1'b0;
`ifndef BETA_DMEM_STALL_INJECT_EN
        checks++; if (a_req_ready !== 1'b1) begin errors++; $display("FAIL bp_release_req_ready got=%b exp=1", a_req_ready); end
`endif
        checks++; if (a_rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_release_rsp_valid got=%b exp=0", a_rsp_valid); end
    endtask

    task automatic test_random();
        logic [31:0] rd, erd; logic e, ee; int lat; int bad;
        for (int i = 0; i < DEPTH; i++) begin
            do_xact(1'b1, 2'b00, 32'(i * 4), $urandom, rd, e, erd, ee, lat);
        end
        bad = 0;
        for (int i = 0; i < 150; i++) begin
            do_xact(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 32'($urandom_range(0, DEPTH * 4 + 15)),
                    $urandom, rd, e, erd, ee, lat);
            checks++;
            if (rd !== erd || e !== ee) begin
                errors++;
                if (bad < 5) $display("FAIL random_op %0d got rdata=%h err=%b exp rdata=%h err=%b", i, rd, e, erd, ee);
                bad++;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, erd; logic e, ee; int lat; int idx [DEPTH]; int j, t, bad;
        for (int i = 0; i < DEPTH; i++) idx[i] = i;
        for (int i = DEPTH - 1; i > 0; i--) begin
            j = $urandom_range(0, i); t = idx[i]; idx[i] = idx[j]; idx[j] = t;
        end
        stall_seen = 0;
        for (int i = 0; i < 100; i++) do_xact(1'b1, 2'b00, 32'(idx[i] * 4), $urandom, rd, e, erd, ee, lat);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            do_xact(1'b0, 2'b00, 32'(idx[i] * 4), 32'h0, rd, e, erd, ee, lat);
            checks++;
            if (rd !== erd || e !== 1'b0) begin
                errors++;
                if (bad < 5) $display("FAIL b2b_load %0d got rdata=%h err=%b exp rdata=%h err=0", i, rd, e, erd);
                bad++;
            end
        end
`ifdef BETA_DMEM_STALL_INJECT_EN
        checks++; if (stall_seen == 0) begin errors++; $display("FAIL stall_seen got=0 exp>0"); end
`else
        checks++; if (stall_seen != 0) begin errors++; $display("FAIL stall_seen got=%0d exp=0", stall_seen); end
`endif
    endtask

    task automatic test_reset_mid_wait();
        bit ok; int seen;
        @(negedge clk);
        b_req_valid = 1'b1; b_req_op = 1'b1; b_req_size = 2'b00; b_req_addr = 32'h40; b_req_wdata = 32'h12345678;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (b_req_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (!ok) begin errors++; $display("FAIL rmw_accept got req_ready=0 exp=1"); end
        @(negedge clk);
        b_req_valid = 1'b0;
        checks++; if (b_req_ready !== 1'b0) begin errors++; $display("FAIL rmw_wait_req_ready got=%b exp=0", b_req_ready); end
        @(negedge clk);
        b_rst = 1'b1;
        @(negedge clk);
        checks++; if (b_req_ready !== 1'b1) begin errors++; $display("FAIL rmw_req_ready got=%b exp=1", b_req_ready); end
        checks++; if (b_rsp_valid !== 1'b0) begin errors++; $display("FAIL rmw_rsp_valid got=%b exp=0", b_rsp_valid); end
        checks++; if (b_rsp_err !== 1'b0 || b_rsp_rdata !== 32'd0) begin errors++; $display("FAIL rmw_rsp_fields got err=%b rdata=%h exp 0", b_rsp_err, b_rsp_rdata); end
        b_rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (b_rsp_valid) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL rmw_ghost_response got=%0d cycles exp=0", seen); end
    endtask

    initial begin
        a_rst = 1'b1; a_req_valid = 1'b0; a_req_op = 1'b0; a_req_size = 2'b00; a_req_addr = 32'h0; a_req_wdata = 32'h0; a_rsp_ready = 1'b0;
        b_rst = 1'b1; b_req_valid = 1'b0; b_req_op = 1'b0; b_req_size = 2'b00; b_req_addr = 32'h0; b_req_wdata = 32'h0; b_rsp_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) mdl[i] = 32'h0;
        test_reset();
        test_word();
        test_byte_lanes();
        test_errors();
        test_backpressure();
        test_random();
        test_back_to_back();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog simulation exceeded time limit");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

endmodule
